// File: rtl/beta_mem_model_if.sv
// Bus bundle between the beta core and its memory model.
// Carries the instruction read port (i_*) and the data read/write port (d_*).
interface beta_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction port
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_ready;
    logic                  i_done;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_err;

    // Data port
    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_stall;
    logic                  d_ready;
    logic                  d_done;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;

    // Requester side (core or bench)
    modport master (
        output i_req, i_addr,
        input  i_ready, i_done, i_rdata, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata, d_stall,
        input  d_ready, d_done, d_rdata, d_err
    );

    // Memory side
    modport slave (
        input  i_req, i_addr,
        output i_ready, i_done, i_rdata, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata, d_stall,
        output d_ready, d_done, d_rdata, d_err
    );
endinterface

// File: rtl/beta_mem_model.sv
// Dual-port memory model for the beta core: instruction read port plus data
// read/write port, each with a req/ready handshake, a fixed LAT-cycle latency
// and a registered one-cycle done pulse. The data port also accepts stall
// injection. Array contents survive reset so benches can preload them.
module beta_mem_model #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    beta_mem_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * BYTES);
    localparam logic [3:0]      CNT_INIT  = 4'(LAT - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // Instruction port state
    state_t            i_state_q, i_state_d;
    logic [3:0]        i_cnt_q, i_cnt_d;
    logic [DATA_W-1:0] i_hold_q, i_hold_d;
    logic              i_hold_err_q, i_hold_err_d;
    logic              i_done_q, i_done_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_err_q, i_err_d;

    // Data port state
    state_t            d_state_q, d_state_d;
    logic [3:0]        d_cnt_q, d_cnt_d;
    logic [DATA_W-1:0] d_hold_q, d_hold_d;
    logic              d_hold_err_q, d_hold_err_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    logic [IDX_W-1:0]  i_idx, d_idx;
    logic              i_in_range, d_in_range;
    logic              i_finish, d_finish;
    logic              i_ready, d_ready;
    logic              i_accept, d_accept;

    // Low byte-offset bits are dropped, so misaligned addresses simply hit the containing word.
    assign i_idx      = bus.i_addr[OFF_W +: IDX_W];
    assign d_idx      = bus.d_addr[OFF_W +: IDX_W];
    assign i_in_range = ({1'b0, bus.i_addr} < MEM_BYTES);
    assign d_in_range = ({1'b0, bus.d_addr} < MEM_BYTES);

    // A port may accept on the same edge that completes its current transaction,
    // which gives one request per LAT cycles and continuous ready at LAT=1.
    assign i_finish = (i_state_q == WAIT) && (i_cnt_q == 4'd0);
    assign d_finish = (d_state_q == WAIT) && (d_cnt_q == 4'd0) && !bus.d_stall;
    assign i_ready  = (i_state_q == IDLE) || i_finish;
    assign d_ready  = (d_state_q == IDLE) || d_finish;
    assign i_accept = bus.i_req && i_ready;
    assign d_accept = bus.d_req && d_ready;

    // Instruction port next state: count down, complete, and capture the word at accept.
    always_comb begin
        i_state_d    = i_state_q;
        i_cnt_d      = i_cnt_q;
        i_hold_d     = i_hold_q;
        i_hold_err_d = i_hold_err_q;
        i_done_d     = 1'b0;
        i_rdata_d    = '0;
        i_err_d      = 1'b0;
        if (i_state_q == WAIT) begin
            if (i_cnt_q == 4'd0) begin
                i_state_d = IDLE;
                i_done_d  = 1'b1;
                i_rdata_d = i_hold_q;
                i_err_d   = i_hold_err_q;
            end else begin
                i_cnt_d = i_cnt_q - 4'd1;
            end
        end
        if (i_accept) begin
            i_state_d    = WAIT;
            i_cnt_d      = CNT_INIT;
            i_hold_d     = i_in_range ? mem[i_idx] : '0;
            i_hold_err_d = !i_in_range;
        end
    end

    // Data port next state: same as the instruction port, but stall freezes the countdown.
    always_comb begin
        d_state_d    = d_state_q;
        d_cnt_d      = d_cnt_q;
        d_hold_d     = d_hold_q;
        d_hold_err_d = d_hold_err_q;
        d_done_d     = 1'b0;
        d_rdata_d    = '0;
        d_err_d      = 1'b0;
        if ((d_state_q == WAIT) && !bus.d_stall) begin
            if (d_cnt_q == 4'd0) begin
                d_state_d = IDLE;
                d_done_d  = 1'b1;
                d_rdata_d = d_hold_q;
                d_err_d   = d_hold_err_q;
            end else begin
                d_cnt_d = d_cnt_q - 4'd1;
            end
        end
        if (d_accept) begin
            d_state_d    = WAIT;
            d_cnt_d      = CNT_INIT;
            d_hold_d     = (!bus.d_we && d_in_range) ? mem[d_idx] : '0;
            d_hold_err_d = !d_in_range;
        end
    end

    // Both port FSMs and their registered outputs; reset abandons anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_state_q    <= IDLE;
            i_cnt_q      <= 4'd0;
            i_hold_q     <= '0;
            i_hold_err_q <= 1'b0;
            i_done_q     <= 1'b0;
            i_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_state_q    <= IDLE;
            d_cnt_q      <= 4'd0;
            d_hold_q     <= '0;
            d_hold_err_q <= 1'b0;
            d_done_q     <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
        end else begin
            i_state_q    <= i_state_d;
            i_cnt_q      <= i_cnt_d;
            i_hold_q     <= i_hold_d;
            i_hold_err_q <= i_hold_err_d;
            i_done_q     <= i_done_d;
            i_rdata_q    <= i_rdata_d;
            i_err_q      <= i_err_d;
            d_state_q    <= d_state_d;
            d_cnt_q      <= d_cnt_d;
            d_hold_q     <= d_hold_d;
            d_hold_err_q <= d_hold_err_d;
            d_done_q     <= d_done_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    // Byte-lane writes commit at the accept edge; out-of-range writes never touch the array.
    always_ff @(posedge clk) begin
        if (rst && d_accept && bus.d_we && d_in_range) begin
            for (int k = 0; k < BYTES; k++) begin
                if (bus.d_be[k]) begin
                    mem[d_idx][8*k +: 8] <= bus.d_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.i_ready = i_ready;
    assign bus.i_done  = i_done_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.i_err   = i_err_q;
    assign bus.d_ready = d_ready;
    assign bus.d_done  = d_done_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_err   = d_err_q;
endmodule

// File: tb/tb_beta_mem_model.sv
// Directed bench for beta_mem_model. Four instances with LAT = 1..4 sit side by
// side; instance n has LAT = n+1. Each task drives one scenario and checks it inline.
module tb_beta_mem_model;
    logic clk;
    logic rst;

    logic        i_req   [4];
    logic [31:0] i_addr  [4];
    logic        i_ready [4];
    logic        i_done  [4];
    logic [31:0] i_rdata [4];
    logic        i_err   [4];
    logic        d_req   [4];
    logic        d_we    [4];
    logic [3:0]  d_be    [4];
    logic [31:0] d_addr  [4];
    logic [31:0] d_wdata [4];
    logic        d_stall [4];
    logic        d_ready [4];
    logic        d_done  [4];
    logic [31:0] d_rdata [4];
    logic        d_err   [4];

    int tests_run;
    int tests_failed;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        beta_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        assign bus.i_req   = i_req[g];
        assign bus.i_addr  = i_addr[g];
        assign bus.d_req   = d_req[g];
        assign bus.d_we    = d_we[g];
        assign bus.d_be    = d_be[g];
        assign bus.d_addr  = d_addr[g];
        assign bus.d_wdata = d_wdata[g];
        assign bus.d_stall = d_stall[g];
        assign i_ready[g]  = bus.i_ready;
        assign i_done[g]   = bus.i_done;
        assign i_rdata[g]  = bus.i_rdata;
        assign i_err[g]    = bus.i_err;
        assign d_ready[g]  = bus.d_ready;
        assign d_done[g]   = bus.d_done;
        assign d_rdata[g]  = bus.d_rdata;
        assign d_err[g]    = bus.d_err;

        beta_mem_model #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LAT(g + 1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit in case a handshake never completes
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One data transaction; cycles = edges from accept to the done pulse (50 = timed out)
    task automatic d_access(input int n, input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, output logic [31:0] rdata, output logic err, output int cycles);
        int guard;
        guard = 0;
        d_req[n] = 1'b1; d_we[n] = we; d_addr[n] = addr; d_be[n] = be; d_wdata[n] = wdata;
        while (d_ready[n] !== 1'b1 && guard < 50) begin tick(); guard++; end
        tick();
        d_req[n] = 1'b0; d_we[n] = 1'b0; d_addr[n] = 32'hFFFF_FFFF; d_be[n] = 4'hF; d_wdata[n] = 32'hFFFF_FFFF;
        cycles = 0;
        while (d_done[n] !== 1'b1 && cycles < 50) begin tick(); cycles++; end
        rdata = d_rdata[n];
        err   = d_err[n];
    endtask

    // One instruction fetch; cycles as for d_access
    task automatic i_access(input int n, input logic [31:0] addr, output logic [31:0] rdata,
                            output logic err, output int cycles);
        int guard;
        guard = 0;
        i_req[n] = 1'b1; i_addr[n] = addr;
        while (i_ready[n] !== 1'b1 && guard < 50) begin tick(); guard++; end
        tick();
        i_req[n] = 1'b0; i_addr[n] = 32'hFFFF_FFFF;
        cycles = 0;
        while (i_done[n] !== 1'b1 && cycles < 50) begin tick(); cycles++; end
        rdata = i_rdata[n];
        err   = i_err[n];
    endtask

    // While reset is held, every instance must be idle with quiet outputs
    task automatic test_reset();
        for (int n = 0; n < 4; n++) begin
            tests_run++; if (i_ready[n] !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_i_ready[%0d]: got %0b want 1", n, i_ready[n]); end
            tests_run++; if (d_ready[n] !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_d_ready[%0d]: got %0b want 1", n, d_ready[n]); end
            tests_run++; if (i_done[n] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_i_done[%0d]: got %0b want 0", n, i_done[n]); end
            tests_run++; if (d_done[n] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_d_done[%0d]: got %0b want 0", n, d_done[n]); end
            tests_run++; if (i_rdata[n] !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_i_rdata[%0d]: got %h want 0", n, i_rdata[n]); end
            tests_run++; if (d_rdata[n] !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_d_rdata[%0d]: got %h want 0", n, d_rdata[n]); end
            tests_run++; if (i_err[n] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_i_err[%0d]: got %0b want 0", n, i_err[n]); end
            tests_run++; if (d_err[n] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_d_err[%0d]: got %0b want 0", n, d_err[n]); end
        end
    endtask

    // LAT=1: fetches complete one cycle after accept and ready never drops, even back to back
    task automatic test_lat1_fetch();
        logic [31:0] rd; logic er; int cy;
        d_access(0, 1'b1, 32'd20, 4'hF, 32'hDEADBEEF, rd, er, cy);
        tests_run++; if (cy !== 1) begin tests_failed++; $display("[TB] FAIL lat1_wr_latency: got %0d want 1", cy); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL lat1_wr_rdata: got %h want 0", rd); end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat1_wr_err: got %0b want 0", er); end
        d_access(0, 1'b1, 32'd24, 4'hF, 32'h0BADF00D, rd, er, cy);

        i_req[0] = 1'b1; i_addr[0] = 32'd20;
        tests_run++; if (i_ready[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat1_ready_pre: got %0b want 1", i_ready[0]); end
        tick();
        i_addr[0] = 32'd24;
        tests_run++; if (i_ready[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat1_ready_wait: got %0b want 1", i_ready[0]); end
        tests_run++; if (i_done[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat1_done_early: got %0b want 0", i_done[0]); end
        tick();
        i_req[0] = 1'b0;
        tests_run++; if (i_done[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat1_done1: got %0b want 1", i_done[0]); end
        tests_run++; if (i_rdata[0] !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL lat1_rdata1: got %h want deadbeef", i_rdata[0]); end
        tests_run++; if (i_err[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat1_err1: got %0b want 0", i_err[0]); end
        tests_run++; if (i_ready[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat1_ready_done: got %0b want 1", i_ready[0]); end
        tick();
        tests_run++; if (i_done[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat1_done2: got %0b want 1", i_done[0]); end
        tests_run++; if (i_rdata[0] !== 32'h0BADF00D) begin tests_failed++; $display("[TB] FAIL lat1_rdata2: got %h want 0badf00d", i_rdata[0]); end
        tick();
        tests_run++; if (i_done[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat1_done_after: got %0b want 0", i_done[0]); end
        tests_run++; if (i_rdata[0] !== 32'h0) begin tests_failed++; $display("[TB] FAIL lat1_rdata_after: got %h want 0", i_rdata[0]); end
    endtask

    // LAT=3: partial byte-enable write merges into the old word
    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int cy;
        d_access(2, 1'b1, 32'h40, 4'hF, 32'hAAAAAAAA, rd, er, cy);
        d_access(2, 1'b1, 32'h40, 4'b0101, 32'h11223344, rd, er, cy);
        tests_run++; if (cy !== 3) begin tests_failed++; $display("[TB] FAIL be_wr_latency: got %0d want 3", cy); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL be_wr_rdata: got %h want 0", rd); end
        d_access(2, 1'b0, 32'h40, 4'h0, 32'h0, rd, er, cy);
        tests_run++; if (cy !== 3) begin tests_failed++; $display("[TB] FAIL be_rd_latency: got %0d want 3", cy); end
        tests_run++; if (rd !== 32'hAA22AA44) begin tests_failed++; $display("[TB] FAIL be_rd_rdata: got %h want aa22aa44", rd); end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("[TB] FAIL be_rd_err: got %0b want 0", er); end
    endtask

    // LAT=3 with req held: second accept lands on the first completion edge
    task automatic test_back_to_back();
        logic [6:1] mask;
        logic [31:0] last;
        mask = '0;
        last = 32'h0;
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h40; d_be[2] = 4'h0;
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            mask[k] = d_done[2];
            if (d_done[2] === 1'b1) last = d_rdata[2];
            if (k == 3) d_req[2] = 1'b0;
        end
        tests_run++; if (mask !== 6'b100100) begin tests_failed++; $display("[TB] FAIL b2b_done_pattern: got %b want 100100", mask); end
        tests_run++; if (last !== 32'hAA22AA44) begin tests_failed++; $display("[TB] FAIL b2b_rdata: got %h want aa22aa44", last); end
    endtask

    // LAT=2 with 4 stall cycles right after accept: done moves to accept+6
    task automatic test_stall();
        logic [31:0] rd; logic er; int cy;
        logic seen_ready, seen_done;
        d_access(1, 1'b1, 32'h40, 4'hF, 32'h12345678, rd, er, cy);
        tests_run++; if (cy !== 2) begin tests_failed++; $display("[TB] FAIL stall_plain_latency: got %0d want 2", cy); end
        seen_ready = 1'b0; seen_done = 1'b0;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h40;
        tick();
        d_req[1] = 1'b0; d_stall[1] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (d_ready[1] === 1'b1) seen_ready = 1'b1;
            if (d_done[1] === 1'b1) seen_done = 1'b1;
            tick();
        end
        if (d_ready[1] === 1'b1) seen_ready = 1'b1;
        d_stall[1] = 1'b0;
        tick();
        tests_run++; if (seen_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_ready_low: got %0b want 0", seen_ready); end
        tests_run++; if (d_done[1] !== 1'b0 || seen_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_done_early: got %0b want 0", d_done[1] | seen_done); end
        tick();
        tests_run++; if (d_done[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_done: got %0b want 1", d_done[1]); end
        tests_run++; if (d_rdata[1] !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL stall_rdata: got %h want 12345678", d_rdata[1]); end
        tests_run++; if (d_ready[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_ready_done: got %0b want 1", d_ready[1]); end
    endtask

    // Out-of-range accesses complete with err and leave the array alone; last word is in range
    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int cy;
        logic [31:0] cs_before, cs_after;
        d_access(0, 1'b1, 32'hFFC, 4'hF, 32'h600DCAFE, rd, er, cy);
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("[TB] FAIL oor_lastword_err: got %0b want 0", er); end
        i_access(0, 32'hFFC, rd, er, cy);
        tests_run++; if (rd !== 32'h600DCAFE) begin tests_failed++; $display("[TB] FAIL oor_lastword_rdata: got %h want 600dcafe", rd); end
        cs_before = 32'h0;
        for (int k = 0; k < 1024; k++) cs_before = {cs_before[30:0], cs_before[31]} ^ g_dut[0].u_dut.mem[k];
        d_access(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, rd, er, cy);
        tests_run++; if (er !== 1'b1) begin tests_failed++; $display("[TB] FAIL oor_wr_err: got %0b want 1", er); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL oor_wr_rdata: got %h want 0", rd); end
        tests_run++; if (cy !== 1) begin tests_failed++; $display("[TB] FAIL oor_wr_latency: got %0d want 1", cy); end
        cs_after = 32'h0;
        for (int k = 0; k < 1024; k++) cs_after = {cs_after[30:0], cs_after[31]} ^ g_dut[0].u_dut.mem[k];
        tests_run++; if (cs_after !== cs_before) begin tests_failed++; $display("[TB] FAIL oor_checksum: got %h want %h", cs_after, cs_before); end
        d_access(0, 1'b0, 32'h1000, 4'h0, 32'h0, rd, er, cy);
        tests_run++; if (er !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL oor_d_rd: got err=%0b rdata=%h want err=1 rdata=0", er, rd); end
        i_access(0, 32'h2004, rd, er, cy);
        tests_run++; if (er !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL oor_i_rd: got err=%0b rdata=%h want err=1 rdata=0", er, rd); end
    endtask

    // Same-edge i read and d write to one word: i sees the old word, later reads see the new one
    task automatic test_collision();
        logic [31:0] rd; logic er; int cy;
        d_access(0, 1'b1, 32'd32, 4'hF, 32'h7, rd, er, cy);
        i_req[0] = 1'b1; i_addr[0] = 32'd32;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'd32; d_be[0] = 4'hF; d_wdata[0] = 32'h5;
        tick();
        i_req[0] = 1'b0; d_req[0] = 1'b0; d_we[0] = 1'b0;
        tick();
        tests_run++; if (i_done[0] !== 1'b1 || i_rdata[0] !== 32'h7) begin tests_failed++; $display("[TB] FAIL coll_i_old: got done=%0b rdata=%h want done=1 rdata=7", i_done[0], i_rdata[0]); end
        tests_run++; if (d_done[0] !== 1'b1 || d_err[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL coll_d_done: got done=%0b err=%0b want done=1 err=0", d_done[0], d_err[0]); end
        i_access(0, 32'd32, rd, er, cy);
        tests_run++; if (rd !== 32'h5) begin tests_failed++; $display("[TB] FAIL coll_i_new: got %h want 5", rd); end
        i_access(0, 32'd34, rd, er, cy);
        tests_run++; if (rd !== 32'h5 || er !== 1'b0) begin tests_failed++; $display("[TB] FAIL coll_misaligned: got rdata=%h err=%0b want rdata=5 err=0", rd, er); end
        d_access(0, 1'b0, 32'd32, 4'h0, 32'h0, rd, er, cy);
        tests_run++; if (rd !== 32'h5) begin tests_failed++; $display("[TB] FAIL coll_d_new: got %h want 5", rd); end
    endtask

    // LAT=4: reset one cycle after accept kills both in-flight requests, keeps the committed write
    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int cy;
        logic seen_done;
        d_access(3, 1'b1, 32'h80, 4'hF, 32'hCAFEF00D, rd, er, cy);
        tests_run++; if (cy !== 4) begin tests_failed++; $display("[TB] FAIL rmid_latency: got %0d want 4", cy); end
        i_req[3] = 1'b1; i_addr[3] = 32'h80;
        d_req[3] = 1'b1; d_we[3] = 1'b1; d_addr[3] = 32'h84; d_be[3] = 4'hF; d_wdata[3] = 32'h13579BDF;
        tick();
        i_req[3] = 1'b0; d_req[3] = 1'b0; d_we[3] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (i_done[3] === 1'b1 || d_done[3] === 1'b1) seen_done = 1'b1;
            tick();
        end
        tests_run++; if (seen_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_no_done: got %0b want 0", seen_done); end
        tests_run++; if (i_ready[3] !== 1'b1 || d_ready[3] !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmid_ready: got i=%0b d=%0b want 1 1", i_ready[3], d_ready[3]); end
        tests_run++; if (i_rdata[3] !== 32'h0 || d_rdata[3] !== 32'h0 || i_err[3] !== 1'b0 || d_err[3] !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL rmid_outputs: got i=%h d=%h ie=%0b de=%0b want all 0", i_rdata[3], d_rdata[3], i_err[3], d_err[3]);
        end
        d_access(3, 1'b0, 32'h84, 4'h0, 32'h0, rd, er, cy);
        tests_run++; if (rd !== 32'h13579BDF) begin tests_failed++; $display("[TB] FAIL rmid_committed: got %h want 13579bdf", rd); end
        i_access(3, 32'h80, rd, er, cy);
        tests_run++; if (rd !== 32'hCAFEF00D || cy !== 4) begin tests_failed++; $display("[TB] FAIL rmid_refetch: got rdata=%h lat=%0d want cafef00d 4", rd, cy); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            i_req[n] = 1'b0; i_addr[n] = 32'h0;
            d_req[n] = 1'b0; d_we[n] = 1'b0; d_be[n] = 4'h0; d_addr[n] = 32'h0; d_wdata[n] = 32'h0; d_stall[n] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        tick();
        test_lat1_fetch();
        test_byte_enable();
        test_back_to_back();
        test_stall();
        test_out_of_range();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
